// File: rtl/sccomp_run_ctrl.sv
// sccomp_run_ctrl: run/step/halt sequencer driving the sccomp clock enable.
// Define RUN_CTRL_WDOG_EN to build the stuck-pc watchdog halt.
module sccomp_run_ctrl #(
    parameter int PC_W      = 32,
    parameter int CNT_W     = 32,
    parameter int MAX_INSTR = 0,
    parameter int WDOG_CYC  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run_req,
    input  logic             step_req,
    input  logic             halt_req,
    input  logic             bp_en,
    input  logic [PC_W-1:0]  bp_addr,
    input  logic [PC_W-1:0]  pc,
    output logic             cpu_en,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired,
    output logic             bp_hit,
    output logic             wdog_hit
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        STEP  = 3'd2,
        HALT  = 3'd3,
        BREAK = 3'd4
    } state_t;

    state_t st;
    logic   skip;
    logic   bp_stop;
    logic   limit_stop;
    logic   start;
    logic   wd_fire;

    assign state      = st;
    assign bp_stop    = bp_en && (pc == bp_addr) && !skip;
    assign limit_stop = (MAX_INSTR != 0) &&
                        (retired == CNT_W'(MAX_INSTR));
    assign cpu_en     = (st == RUN && !bp_stop && !limit_stop) ||
                        (st == STEP);

    // a run/step request accepted from a stopped state
    assign start = (st == IDLE || st == HALT || st == BREAK) &&
                   !halt_req && (step_req || run_req);

    // sequencer state, retire counter, skip flag, breakpoint flag
    always_ff @(posedge clk) begin
        if (rst) begin
            st      <= IDLE;
            retired <= '0;
            bp_hit  <= 1'b0;
            skip    <= 1'b0;
        end else begin
            if (cpu_en) begin
                retired <= retired + CNT_W'(1);
                skip    <= 1'b0;
            end
            if (start)
                bp_hit <= 1'b0;
            unique case (st)
                RUN: begin
                    if (halt_req)
                        st <= HALT;
                    else if (bp_stop) begin
                        st     <= BREAK;
                        bp_hit <= 1'b1;
                    end else if (limit_stop)
                        st <= HALT;
                    else if (wd_fire)
                        st <= HALT;
                end
                STEP: st <= HALT;
                default: begin
                    if (halt_req)
                        st <= HALT;
                    else if (step_req) begin
                        st <= STEP;
                        if (st == BREAK)
                            skip <= 1'b1;
                    end else if (run_req) begin
                        st <= RUN;
                        if (st == BREAK)
                            skip <= 1'b1;
                    end
                end
            endcase
        end
    end

`ifdef RUN_CTRL_WDOG_EN
    localparam int WD_W = $clog2(WDOG_CYC + 1);

    logic [PC_W-1:0] pc_prev;
    logic [WD_W-1:0] wd_cnt;
    logic            wd_same;

    assign wd_same = (pc == pc_prev);
    assign wd_fire = (st == RUN) && cpu_en && wd_same &&
                     (wd_cnt == WD_W'(WDOG_CYC - 1));

    // track last executed pc and count repeats while running
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_prev  <= '0;
            wd_cnt   <= '0;
            wdog_hit <= 1'b0;
        end else begin
            if (cpu_en)
                pc_prev <= pc;
            if (st != RUN || wd_fire)
                wd_cnt <= '0;
            else if (cpu_en)
                wd_cnt <= wd_same ? wd_cnt + WD_W'(1) : '0;
            if (wd_fire && !halt_req)
                wdog_hit <= 1'b1;
            else if (start)
                wdog_hit <= 1'b0;
        end
    end
`else
    logic unused_wdog;

    assign unused_wdog = (WDOG_CYC != 0);
    assign wd_fire     = 1'b0;
    assign wdog_hit    = 1'b0;
`endif

endmodule

// File: tb/tb_sccomp_run_ctrl.sv
// tb_sccomp_run_ctrl: directed bench for sccomp_run_ctrl.
// A retire-pc scoreboard runs beside the directed checks.
module tb_sccomp_run_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run_req = 1'b0;
    logic        step_req = 1'b0;
    logic        halt_req = 1'b0;
    logic        bp_en = 1'b0;
    logic [31:0] bp_addr = 32'h0;
    logic [31:0] pc;
    logic        cpu_en;
    logic [2:0]  state;
    logic [31:0] retired;
    logic        bp_hit;
    logic        wdog_hit;

    logic        l_run = 1'b0;
    logic        l_step = 1'b0;
    logic        l_halt = 1'b0;
    logic        l_bp_en = 1'b0;
    logic [31:0] l_pc;
    logic        l_cpu_en;
    logic [2:0]  l_state;
    logic [31:0] l_retired;
    logic        l_bp_hit;
    logic        l_wdog_hit;

    int pass_cnt = 0;
    int fail_cnt = 0;
    int total_cnt = 0;

    logic [31:0] exp_q[$];
    logic [31:0] lim_q[$];

    sccomp_run_ctrl #(
        .PC_W(32), .CNT_W(32), .MAX_INSTR(0), .WDOG_CYC(16)
    ) u_dut (
        .clk(clk), .rst(rst),
        .run_req(run_req), .step_req(step_req), .halt_req(halt_req),
        .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc),
        .cpu_en(cpu_en), .state(state), .retired(retired),
        .bp_hit(bp_hit), .wdog_hit(wdog_hit)
    );

    sccomp_run_ctrl #(
        .PC_W(32), .CNT_W(32), .MAX_INSTR(7), .WDOG_CYC(16)
    ) u_lim (
        .clk(clk), .rst(rst),
        .run_req(l_run), .step_req(l_step), .halt_req(l_halt),
        .bp_en(l_bp_en), .bp_addr(bp_addr), .pc(l_pc),
        .cpu_en(l_cpu_en), .state(l_state), .retired(l_retired),
        .bp_hit(l_bp_hit), .wdog_hit(l_wdog_hit)
    );

    always #5 clk = ~clk;

    // tiny cpu models: pc+4, with a self-jump at 0x20
    always @(posedge clk) begin
        if (rst) pc <= 32'h0;
        else if (cpu_en) pc <= (pc == 32'h20) ? pc : pc + 32'd4;
    end

    always @(posedge clk) begin
        if (rst) l_pc <= 32'h0;
        else if (l_cpu_en) l_pc <= (l_pc == 32'h20) ? l_pc : l_pc + 32'd4;
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // scoreboards: each retiring edge pops the expected pc
    always @(negedge clk) begin
        logic [31:0] e;
        if (rst !== 1'b1 && cpu_en === 1'b1) begin
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hx;
            chk("retire_pc", pc, e);
        end
    end

    always @(negedge clk) begin
        logic [31:0] e;
        if (rst !== 1'b1 && l_cpu_en === 1'b1) begin
            e = (lim_q.size() != 0) ? lim_q.pop_front() : 32'hx;
            chk("lim_retire_pc", l_pc, e);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_st(input string tag, input bit lim,
                           input logic [2:0] s, input int budget);
        int n = 0;
        while (((lim ? l_state : state) !== s) && n < budget) begin
            tick();
            n++;
        end
        chk(tag, lim ? l_state : state, s);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        // reset then idle
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_state", state, 3'd0);
            chk("idle_cpu_en", cpu_en, 1'b0);
            chk("idle_retired", retired, 32'd0);
        end

        // single steps
        exp_q.push_back(32'h0);
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        chk("step_state", state, 3'd2);
        chk("step_cpu_en", cpu_en, 1'b1);
        tick();
        chk("step_done_state", state, 3'd3);
        chk("step_done_cpu_en", cpu_en, 1'b0);
        chk("step_retired1", retired, 32'd1);
        exp_q.push_back(32'h4);
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        chk("step2_state", state, 3'd2);
        tick();
        chk("step2_retired", retired, 32'd2);
        chk("step2_state_halt", state, 3'd3);

        // breakpoint at 0xC from pc 0
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bp_en = 1'b1;
        bp_addr = 32'hC;
        for (int i = 0; i < 3; i++) exp_q.push_back(32'(i * 4));
        run_req = 1'b1;
        tick();
        run_req = 1'b0;
        wait_st("bp_break_state", 1'b0, 3'd4, 20);
        chk("bp_retired", retired, 32'd3);
        chk("bp_hit_set", bp_hit, 1'b1);
        chk("bp_cpu_en", cpu_en, 1'b0);
        tick();
        tick();
        chk("bp_hold_retired", retired, 32'd3);
        chk("bp_hold_state", state, 3'd4);

        // resume executes 0xC once
        exp_q.push_back(32'hC);
        exp_q.push_back(32'h10);
        exp_q.push_back(32'h14);
        run_req = 1'b1;
        tick();
        run_req = 1'b0;
        chk("resume_state", state, 3'd1);
        chk("resume_bp_clr", bp_hit, 1'b0);
        chk("resume_cpu_en", cpu_en, 1'b1);
        tick();
        tick();
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        chk("resume_halt", state, 3'd3);
        chk("resume_retired", retired, 32'd6);

        // all requests together while running
        exp_q.push_back(32'h18);
        run_req = 1'b1;
        tick();
        run_req = 1'b0;
        chk("prio_run", state, 3'd1);
        halt_req = 1'b1;
        step_req = 1'b1;
        run_req = 1'b1;
        tick();
        halt_req = 1'b0;
        step_req = 1'b0;
        run_req = 1'b0;
        chk("prio_halt", state, 3'd3);
        chk("prio_retired", retired, 32'd7);
        chk("prio_cpu_en", cpu_en, 1'b0);

        // reset while running
        exp_q.push_back(32'h1C);
        run_req = 1'b1;
        tick();
        run_req = 1'b0;
        tick();
        chk("midrun_retired", retired, 32'd8);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_state", state, 3'd0);
        chk("rst_retired", retired, 32'd0);
        chk("rst_cpu_en", cpu_en, 1'b0);
        chk("sb_drain1", exp_q.size(), 0);
        bp_en = 1'b0;

        // retire limit of 7
        for (int i = 0; i < 7; i++) lim_q.push_back(32'(i * 4));
        l_run = 1'b1;
        tick();
        l_run = 1'b0;
        chk("lim_run", l_state, 3'd1);
        wait_st("lim_halt", 1'b1, 3'd3, 20);
        chk("lim_retired", l_retired, 32'd7);
        chk("lim_cpu_en", l_cpu_en, 1'b0);
        repeat (3) tick();
        chk("lim_hold", l_retired, 32'd7);
        chk("lim_drain", lim_q.size(), 0);

        // self-jump at 0x20
        for (int i = 0; i < 8; i++) exp_q.push_back(32'(i * 4));
`ifdef RUN_CTRL_WDOG_EN
        for (int i = 0; i < 17; i++) exp_q.push_back(32'h20);
        run_req = 1'b1;
        tick();
        run_req = 1'b0;
        wait_st("wdog_halt", 1'b0, 3'd3, 60);
        chk("wdog_hit", wdog_hit, 1'b1);
        chk("wdog_retired", retired, 32'd25);
`else
        for (int i = 0; i < 30; i++) exp_q.push_back(32'h20);
        run_req = 1'b1;
        tick();
        run_req = 1'b0;
        repeat (37) tick();
        chk("nowd_state", state, 3'd1);
        chk("nowd_hit", wdog_hit, 1'b0);
        chk("nowd_cpu_en", cpu_en, 1'b1);
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        chk("nowd_halt", state, 3'd3);
        chk("nowd_retired", retired, 32'd38);
`endif
        chk("sb_drain2", exp_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
